uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NBYTES, default 2; number of bytes per word, valid range 1..4.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 req0  input  1  requester 0 word request; held high until gnt0 is seen.
REQ-005 data0  input  8*NBYTES  requester 0 word; sampled on the grant edge.
REQ-006 req1  input  1  requester 1 word request; same rules as req0.
REQ-007 data1  input  8*NBYTES  requester 1 word.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse; the word was captured.
REQ-009 done0, done1  output  1 each  one-cycle pulse; the last byte of that requester's word has finished on the line.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 strt_tx  output  1  one-cycle start pulse to uart_tx.
REQ-012 tx_data  output  8  byte to uart_tx; stable from strt_tx until that byte completes.
REQ-013 tx_done  input  1  uart_tx done level (sets at end of frame, clears after the next start).

Function
REQ-014 The state machine SHALL have four states: IDLE, START, WAIT, FIN.
REQ-015 IDLE, any req high at edge k: capture the winner's data into the word register; bcnt<=0; register the winner's ID; state<=START; gnt of the winner high for cycle k+1 only.
REQ-016 Arbitration SHALL be round-robin: when both reqs are high, grant the requester not granted last; a single request is granted immediately.
REQ-017 START: strt_tx=1 for exactly one cycle; tx_data=word byte bcnt, MSB first (bits [8*NBYTES-1 -: 8] for bcnt=0); state<=WAIT.
REQ-018 WAIT: the block SHALL advance only on a tx_done rising edge (tx_done=1 and tx_done_q=0); a stale high tx_done level SHALL be ignored.
REQ-019 WAIT, on a tx_done rising edge with bcnt<NBYTES-1: bcnt<=bcnt+1; state<=START, so the next strt_tx follows 1 cycle after the edge.
REQ-020 WAIT, on a tx_done rising edge with bcnt==NBYTES-1: state<=FIN.
REQ-021 FIN: the owner's done pulse SHALL be high for one cycle; state<=IDLE; arbitration resumes in the following cycle.
REQ-022 The block SHALL NOT grant while busy; requests are held by the requesters, never queued internally.
REQ-023 bcnt width SHALL be 2 bits; bcnt SHALL never exceed NBYTES-1.
REQ-024 tx_data SHALL hold its value in WAIT and SHALL be 8'h00 in IDLE.
REQ-025 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high in any cycle.

Reset
REQ-026 While rst_n=0 at a clock edge, the following SHALL all be cleared: state<=IDLE, gnt*/done*/strt_tx/busy<=0, tx_data<=0, bcnt<=0, tx_done_q<=0, last-grant<=1 (so requester 0 wins the first tie).
REQ-027 Reset mid-word SHALL abandon the word with no done pulse; the first post-reset grant is available on the first edge with rst_n=1.

Structure
REQ-028 A shared package uart_pkg SHALL hold the arb_state_t enum (IDLE, START, WAIT, FIN) and the BAUD_DIV=2604 constant used by the benches.
REQ-029 The round-robin selector SHALL be one sub-module, rr_arb2 (inputs: req0, req1, last; output: winner).
REQ-030 The tx_done edge detector SHALL be a flop inside uart_tx_arb; there SHALL be no other sub-modules.

Verification (bench instantiates uart_tx_arb driving uart_tx, with NBYTES=2)
REQ-031 req0=1 with data0=16'hA55A -> gnt0 in the next cycle; line carries 8'hA5 then 8'h5A (LSB-first frames with start and stop bits); done0 pulses once about 20*2604 cycles later.
REQ-032 req0 and req1 raised in the same cycle after reset -> requester 0 is granted first, requester 1 second; the next simultaneous tie is granted to requester 0 again.
REQ-033 req1 held continuously with data1=16'h0102 while req0 is idle -> back-to-back words are sent; between done1 and the next gnt1 exactly 1 idle cycle.
REQ-034 tx_done held high from a prior frame when strt_tx fires -> no premature advance; the second byte starts only after the new rising edge.
REQ-035 rst_n=0 for 1 cycle during byte 1 -> busy=0, no done pulse, strt_tx=0; the next request is granted normally.
REQ-036 NBYTES=1, data0=8'hC3 -> one frame, then done0; bcnt stays 0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its benches.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        FIN
    } arb_state_t;

    localparam int BAUD_DIV = 2604;
    localparam int BCNT_W   = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    assign winner = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates two word requesters onto one byte-wide uart_tx, sending each word MSB byte first.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0,
    input  logic [8*NBYTES-1:0] data0,
    input  logic                req1,
    input  logic [8*NBYTES-1:0] data1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                done0,
    output logic                done1,
    output logic                busy,
    output logic                strt_tx,
    output logic [7:0]          tx_data,
    input  logic                tx_done
);

    localparam int W = 8 * NBYTES;

    arb_state_t        state;
    logic [W-1:0]      word;
    logic [BCNT_W-1:0] bcnt;
    logic              owner;
    logic              last;
    logic              winner;
    logic              tx_done_q;
    logic              tx_rise;
    logic [W-1:0]      win_data;
    logic [7:0]        next_byte;

    rr_arb2 u_rr (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .winner (winner)
    );

    assign win_data = winner ? data1 : data0;
    // uart_tx holds tx_done high after a frame, so only its rising edge means "byte finished"
    assign tx_rise  = tx_done & ~tx_done_q;

    always_comb begin
        next_byte = word[W-1 -: 8];
        for (int i = 0; i < NBYTES; i++) begin
            if (int'(bcnt) + 1 == i) next_byte = word[W-1-8*i -: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            word      <= '0;
            bcnt      <= '0;
            owner     <= 1'b0;
            last      <= 1'b1;
            tx_done_q <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            busy      <= 1'b0;
            strt_tx   <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            tx_done_q <= tx_done;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            strt_tx   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        word    <= win_data;
                        bcnt    <= '0;
                        owner   <= winner;
                        last    <= winner;
                        gnt0    <= ~winner;
                        gnt1    <= winner;
                        strt_tx <= 1'b1;
                        tx_data <= win_data[W-1 -: 8];
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (tx_rise) begin
                        if (bcnt == BCNT_W'(NBYTES - 1)) begin
                            done0 <= ~owner;
                            done1 <= owner;
                            state <= FIN;
                        end else begin
                            bcnt    <= bcnt + 2'd1;
                            tx_data <= next_byte;
                            strt_tx <= 1'b1;
                            state   <= START;
                        end
                    end
                end
                FIN: begin
                    busy    <= 1'b0;
                    tx_data <= 8'h00;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
